div_sched_ctrl: RTL and testbench
=================================

// Module: div_sched_ctrl
// PURPOSE
//  Shares one iterative unsigned divider among NREQ requesters. Round-robin arbitration, one restoring
//  step per clock via the div_step sub-module, and a single registered response channel tagged with the
//  requester id. Sits between the calculator's operand sources and its result writeback.
// PARAMETERS
//  N     32  operand, quotient and remainder width
//  NREQ  2   number of requesters (>=2); IDW = $clog2(NREQ)
// PORTS
//  clk           in   1         clock; all state updates on rising edge
//  rst_n         in   1         asynchronous active-low reset
//  req_valid     in   NREQ      per-requester request valid
//  req_ready     out  NREQ      per-requester accept (one-hot or zero)
//  req_a         in   NREQ*N    dividends, requester i at [i*N +: N]
//  req_b         in   NREQ*N    divisors, same packing
//  rsp_valid     out  1         response valid
//  rsp_ready     in   1         response accept
//  rsp_id        out  IDW       index of the requester that issued this operation
//  rsp_quotient  out  N         A / B (unsigned)
//  rsp_dbz       out  1         divide-by-zero flag
//  rsp_remainder out  N         A % B; present only with DIV_REM_EN
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=NREQ-1, rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_dbz=0, rsp_remainder=0, cnt=0.
//   Asserting rst_n low mid-operation aborts it; the operation is lost and never answered.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: grant the first valid requester after rr_ptr (wrapping). req_ready[g]=1 only in IDLE, only for
//    the granted g, combinational from req_valid. On handshake, latch A, B and id; set rr_ptr=g.
//    If B==0, go to DONE. Otherwise load P=0 and Q=A, set cnt=N, go to BUSY.
//   BUSY: each cycle div_step performs one restoring step and cnt decrements. When cnt reaches 1, go to DONE.
//   DONE: rsp_valid=1 and all rsp_* outputs are held stable until rsp_ready. On rsp_valid & rsp_ready,
//    go to IDLE. A new grant is possible in the following cycle, not the same cycle.
//  Latency, accept edge to rsp_valid high: N+1 cycles for B!=0; 1 cycle for B==0.
//  Arithmetic: partial remainder P is N+1 bits wide.
//   Each step: T = {P[N-1:0], Q[N-1]} - {1'b0, B}.
//   If T[N]==1: restore P and shift in quotient bit 0. Else: P=T and shift in quotient bit 1.
//   The step is exact over the full unsigned range, including B >= 2^(N-1).
//  Divide by zero: rsp_dbz=1, rsp_quotient = all ones, rsp_remainder = A. For B!=0, rsp_dbz=0.
//  Unselected requesters see req_ready=0 and must hold their request. No requester is starved: the
//   worst-case wait is (NREQ-1) operations.
//  req_a and req_b are ignored outside the handshake cycle.
// CONFIGURATION
//  DIV_REM_EN defined: rsp_remainder port and remainder register present; P[N-1:0] is latched into it at DONE.
//  DIV_REM_EN undefined: no rsp_remainder port. Quotient, flag, timing and all other behaviour are identical.
// STRUCTURE
//  Package div_pkg: typedef div_state_e {IDLE, BUSY, DONE}; localparam DIV_N_DEFAULT = 32;
//   function to compute the count width ($clog2(N+1)).
//  Sub-module div_step: purely combinational, one restoring iteration.
//   Inputs P[N:0], Q[N-1:0], B[N-1:0]; outputs P_next, Q_next.
//  The top holds the FSM, round-robin arbiter, counter and response registers.
// TESTING
//  1. Req0 A=100 B=10, rsp_ready=1: quotient=10, rem=0, id=0, dbz=0; rsp_valid exactly 33 cycles after accept.
//  2. Req1 A=16 B=3: quotient=5, rem=1, id=1. Then A=255 B=5: quotient=51, rem=0.
//  3. Req0 and req1 valid together, back-to-back: grants alternate 0,1,0,1; rsp_id sequence matches;
//   idle cycle between operations.
//  4. A=7 B=0: rsp_valid 1 cycle after accept; dbz=1, quotient=32'hFFFFFFFF, rem=7.
//  5. A=32'hFFFFFFFF B=32'h80000000: quotient=1, rem=32'h7FFFFFFF. Hold rsp_ready=0 for 10 cycles:
//   outputs stable, all req_ready=0.
//  6. rst_n low at cycle 5 of BUSY: rsp_valid=0 immediately; no response issued; next request completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the shared iterative divider controller.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_N_DEFAULT = 32;

  function automatic int div_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic [N:0]   p,
  input  logic [N-1:0] q,
  input  logic [N-1:0] b,
  output logic [N:0]   p_next,
  output logic [N-1:0] q_next
);

  logic [N:0] shifted;
  logic [N:0] trial;
  logic       unused_p_msb;

  // The partial remainder always stays below b, so its top bit is never set
  // and the extra bit of trial is a reliable borrow even for b >= 2^(N-1).
  assign unused_p_msb = p[N];

  always_comb begin
    shifted = {p[N-1:0], q[N-1]};
    trial   = shifted - {1'b0, b};
    if (trial[N]) begin
      p_next = shifted;
      q_next = {q[N-2:0], 1'b0};
    end else begin
      p_next = trial;
      q_next = {q[N-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_sched_ctrl.sv
// Round-robin scheduler sharing one iterative unsigned divider among NREQ requesters.
// Optional remainder output is enabled by defining DIV_REM_EN.
module div_sched_ctrl
  import div_pkg::*;
#(
  parameter int N    = DIV_N_DEFAULT,
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_quotient,
  output logic              rsp_dbz
`ifdef DIV_REM_EN
  ,
  output logic [N-1:0]      rsp_remainder
`endif
);

  localparam int CW = div_cnt_width(N);

  div_state_e     state;
  div_state_e     state_next;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_id;
  logic           grant_found;
  logic           accept;
  logic [N-1:0]   a_sel;
  logic [N-1:0]   b_sel;
  logic [IDW-1:0] id_q;
  logic [N-1:0]   b_q;
  logic [N:0]     p_q;
  logic [N-1:0]   q_q;
  logic [N:0]     p_step;
  logic [N-1:0]   q_step;
  logic [CW-1:0]  cnt;
  logic           dbz_q;

  // Scan from farthest to nearest after rr_ptr so the nearest valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant_id    = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    accept    = (state == IDLE) && grant_found;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end
    a_sel = req_a[int'(grant_id)*N +: N];
    b_sel = req_b[int'(grant_id)*N +: N];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (b_sel == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (rsp_valid && rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  div_step #(.N(N)) u_step (
    .p      (p_q),
    .q      (q_q),
    .b      (b_q),
    .p_next (p_step),
    .q_next (q_step)
  );

  // Divide by zero preloads the registers so DONE can latch them uniformly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= IDW'(NREQ - 1);
      id_q   <= '0;
      b_q    <= '0;
      p_q    <= '0;
      q_q    <= '0;
      cnt    <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr <= grant_id;
            id_q   <= grant_id;
            b_q    <= b_sel;
            if (b_sel == '0) begin
              dbz_q <= 1'b1;
              q_q   <= '1;
              p_q   <= {1'b0, a_sel};
              cnt   <= '0;
            end else begin
              dbz_q <= 1'b0;
              q_q   <= a_sel;
              p_q   <= '0;
              cnt   <= CW'(N);
            end
          end
        end
        BUSY: begin
          p_q <= p_step;
          q_q <= q_step;
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_dbz       <= 1'b0;
`ifdef DIV_REM_EN
      rsp_remainder <= '0;
`endif
    end else if (state == DONE) begin
      if (!rsp_valid) begin
        rsp_valid     <= 1'b1;
        rsp_id        <= id_q;
        rsp_quotient  <= q_q;
        rsp_dbz       <= dbz_q;
`ifdef DIV_REM_EN
        rsp_remainder <= p_q[N-1:0];
`endif
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Self-checking bench for div_sched_ctrl: directed cases plus randomized traffic
// checked every cycle against a latency/arithmetic model.
module tb_div_sched_ctrl;

  localparam int N    = 32;
  localparam int NREQ = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:0]        rsp_id;
  logic [N-1:0]      rsp_quotient;
  logic              rsp_dbz;
`ifdef DIV_REM_EN
  logic [N-1:0]      rsp_remainder;
`endif

  int numCompared = 0;
  int numFailed   = 0;

  div_sched_ctrl #(.N(N), .NREQ(NREQ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_quotient (rsp_quotient),
    .rsp_dbz      (rsp_dbz)
`ifdef DIV_REM_EN
    ,
    .rsp_remainder(rsp_remainder)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  // Reference: 0 = free, 1 = computing (m_left cycles to response), 2 = presenting response.
  int          m_phase;
  int          m_rr;
  int          m_left;
  int          m_id;
  logic [31:0] m_a;
  logic [31:0] m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_rr    = NREQ - 1;
      m_left  = 0;
    end else begin
      case (m_phase)
        0: begin
          int g;
          g = pick(req_valid, m_rr);
          if (g >= 0) begin
            m_rr    = g;
            m_id    = g;
            m_a     = req_a[g*N +: N];
            m_b     = req_b[g*N +: N];
            m_left  = (m_b == 0) ? 1 : N + 1;
            m_phase = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: begin
          if (rsp_ready) m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [NREQ-1:0] exp_ready;
      int p;
      exp_ready = '0;
      if (m_phase == 0) begin
        p = pick(req_valid, m_rr);
        if (p >= 0) exp_ready[p] = 1'b1;
      end
      checkOutput("req_ready", req_ready, exp_ready);
      checkOutput("rsp_valid", rsp_valid, m_phase == 2);
      if (m_phase == 2) begin
        checkOutput("rsp_id", rsp_id, m_id);
        checkOutput("rsp_dbz", rsp_dbz, m_b == 0);
        checkOutput("rsp_quotient", rsp_quotient, (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b);
`ifdef DIV_REM_EN
        checkOutput("rsp_remainder", rsp_remainder, (m_b == 0) ? m_a : m_a % m_b);
`endif
      end
    end
  end

  // One directed operation with hand-computed expectations.
  task automatic applyStimulus(input int id, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_q, input logic [31:0] exp_r,
                               input logic exp_dbz, input int exp_lat, input int hold_cycles);
    int waited;
    int lat;
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
    req_valid[id]    = 1'b1;
    rsp_ready        = (hold_cycles == 0);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!req_ready[id] && waited < 60);
    if (!req_ready[id]) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!rsp_valid && lat < 100);
    checkOutput("latency", lat, exp_lat);
    checkOutput("quotient", rsp_quotient, exp_q);
    checkOutput("id", rsp_id, id);
    checkOutput("dbz", rsp_dbz, exp_dbz);
`ifdef DIV_REM_EN
    checkOutput("remainder", rsp_remainder, exp_r);
`else
    if (exp_r != exp_r + 32'd1) checkOutput("no_rem_valid", rsp_valid, 1);
`endif
    if (hold_cycles > 0) begin
      req_valid = '1;
      repeat (hold_cycles) begin
        @(negedge clk);
        checkOutput("hold_valid", rsp_valid, 1);
        checkOutput("hold_quotient", rsp_quotient, exp_q);
        checkOutput("hold_ready", req_ready, 0);
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runRoundRobin();
    int got[4];
    int expv[4];
    int accepts;
    int resp;
    expv = '{0, 1, 0, 1};
    got  = '{-1, -1, -1, -1};
    req_a = {32'd999, 32'd1000};
    req_b = {32'd9, 32'd7};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    accepts = 0;
    resp = 0;
    for (int c = 0; c < 400 && resp < 4; c++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 0) accepts++;
      if (rsp_valid) begin
        got[resp] = rsp_id;
        resp++;
      end
      @(posedge clk);
      #1;
      if (accepts >= 4) req_valid = '0;
    end
    req_valid = '0;
    checkOutput("rr_responses", resp, 4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rr_id%0d", i), got[i], expv[i]);
  endtask

  task automatic runResetAbort();
    int waited;
    req_a[0 +: N] = 32'd50;
    req_b[0 +: N] = 32'd7;
    req_valid[0] = 1'b1;
    rsp_ready = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!req_ready[0] && waited < 60);
    checkOutput("abort_accept", req_ready[0], 1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("abort_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      checkOutput("abort_no_rsp", rsp_valid, 0);
    end
    applyStimulus(0, 32'd50, 32'd7, 32'd7, 32'd1, 1'b0, 33, 0);
  endtask

  task automatic runRandom(input int cycles);
    logic [NREQ-1:0] hs;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_a[i*N +: N] = $urandom;
          case ($urandom_range(0, 3))
            0:       req_b[i*N +: N] = 32'd0;
            1:       req_b[i*N +: N] = $urandom_range(1, 15);
            2:       req_b[i*N +: N] = $urandom;
            default: req_b[i*N +: N] = 32'h8000_0000 | $urandom;
          endcase
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (80) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_id", rsp_id, 0);
    checkOutput("reset_rsp_quotient", rsp_quotient, 0);
    checkOutput("reset_rsp_dbz", rsp_dbz, 0);
`ifdef DIV_REM_EN
    checkOutput("reset_rsp_remainder", rsp_remainder, 0);
`endif
    checkOutput("reset_req_ready", req_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] directed operations");
    applyStimulus(0, 32'd100, 32'd10, 32'd10, 32'd0, 1'b0, 33, 0);
    applyStimulus(1, 32'd16, 32'd3, 32'd5, 32'd1, 1'b0, 33, 0);
    applyStimulus(1, 32'd255, 32'd5, 32'd51, 32'd0, 1'b0, 33, 0);
    applyStimulus(0, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1, 1, 0);
    applyStimulus(1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 33, 10);

    $display("[TB] round-robin back-to-back");
    runRoundRobin();
    repeat (60) @(posedge clk);
    #1;

    $display("[TB] reset during operation");
    runResetAbort();

    $display("[TB] randomized traffic");
    runRandom(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numFailed);
    $finish;
  end

endmodule
